// File: rtl/arp_pkg.sv
// rtl/arp_pkg.sv - ARP/Ethernet field constants, request frame layout and FSM state encoding
package arp_pkg;

  localparam logic [15:0] ETH_TYPE_ARP   = 16'h0806;
  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  ARP_HLEN_ETH   = 8'h06;
  localparam logic [7:0]  ARP_PLEN_IPV4  = 8'h04;
  localparam logic [15:0] ARP_OPER_REQ   = 16'h0001;
  localparam logic [15:0] ARP_OPER_REP   = 16'h0002;

  localparam int ARP_FRAME_LEN = 42;
  localparam int ETH_MIN_LEN   = 60;

  // Byte offsets within the Ethernet frame
  localparam int OFF_DST   = 0;
  localparam int OFF_SRC   = 6;
  localparam int OFF_ETYPE = 12;
  localparam int OFF_HTYPE = 14;
  localparam int OFF_PTYPE = 16;
  localparam int OFF_HLEN  = 18;
  localparam int OFF_PLEN  = 19;
  localparam int OFF_OPER  = 20;
  localparam int OFF_SHA   = 22;
  localparam int OFF_SPA   = 28;
  localparam int OFF_THA   = 32;
  localparam int OFF_TPA   = 38;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  // Byte idx of a broadcast ARP request; anything past the ARP payload reads as zero padding.
  function automatic logic [7:0] arp_frame_byte(input logic [5:0]  idx,
                                                input logic [47:0] smac,
                                                input logic [31:0] sip,
                                                input logic [31:0] tip);
    logic [7:0] f [0:63];
    for (int i = 0; i < 64; i++) f[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      f[OFF_DST + i] = 8'hff;
      f[OFF_SRC + i] = smac[8*(5-i) +: 8];
      f[OFF_SHA + i] = smac[8*(5-i) +: 8];
      f[OFF_THA + i] = 8'h00;
    end
    f[OFF_ETYPE]     = ETH_TYPE_ARP[15:8];
    f[OFF_ETYPE + 1] = ETH_TYPE_ARP[7:0];
    f[OFF_HTYPE]     = ARP_HTYPE_ETH[15:8];
    f[OFF_HTYPE + 1] = ARP_HTYPE_ETH[7:0];
    f[OFF_PTYPE]     = ARP_PTYPE_IPV4[15:8];
    f[OFF_PTYPE + 1] = ARP_PTYPE_IPV4[7:0];
    f[OFF_HLEN]      = ARP_HLEN_ETH;
    f[OFF_PLEN]      = ARP_PLEN_IPV4;
    f[OFF_OPER]      = ARP_OPER_REQ[15:8];
    f[OFF_OPER + 1]  = ARP_OPER_REQ[7:0];
    for (int i = 0; i < 4; i++) begin
      f[OFF_SPA + i] = sip[8*(3-i) +: 8];
      f[OFF_TPA + i] = tip[8*(3-i) +: 8];
    end
    return f[idx];
  endfunction

endpackage

// File: rtl/arp_req_timer.sv
// rtl/arp_req_timer.sv - per-attempt reply timeout counter; saturates at timeout_cycles-1 and flags it
module arp_req_timer #(
  parameter int timeout_cycles = 125_000_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int            TW   = $clog2(timeout_cycles);
  localparam logic [TW-1:0] LAST = TW'(timeout_cycles - 1);

  logic [TW-1:0] count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + TW'(1);
    end
  end

  assign tc = en && (count == LAST);

endmodule

// File: rtl/arp_request.sv
// rtl/arp_request.sv - ARP initiator: broadcast request, await matching reply, retry on timeout.
// ARP_REQ_PAD_EN: pad the request with zeros to the 60-byte Ethernet minimum.
module arp_request
  import arp_pkg::*;
#(
  parameter logic [47:0] local_mac      = 48'h00_0a_35_01_02_03,
  parameter logic [31:0] local_ip       = 32'h10_00_00_80,
  parameter int          timeout_cycles = 125_000_000,
  parameter int          max_retries    = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_ip,
  output logic        tx_tvalid,
  input  logic        tx_tready,
  output logic [7:0]  tx_tdata,
  output logic        tx_tlast,
  output logic        tx_tuser,
  input  logic        arp_reply_valid,
  input  logic [31:0] arp_reply_ip,
  input  logic [47:0] arp_reply_mac,
  output logic        res_valid,
  output logic        res_fail,
  output logic [47:0] res_mac
);

`ifdef ARP_REQ_PAD_EN
  localparam int FRAME_LEN = ETH_MIN_LEN;
`else
  localparam int FRAME_LEN = ARP_FRAME_LEN;
`endif
  localparam int              RW        = (max_retries > 0) ? $clog2(max_retries + 1) : 1;
  localparam logic [5:0]      LAST_IDX  = 6'(FRAME_LEN - 1);
  localparam logic [RW-1:0]   MAX_RETRY = RW'(max_retries);

  state_t        state, state_nxt;
  logic [5:0]    byte_idx;
  logic [31:0]   target;
  logic [RW-1:0] retry_cnt;
  logic          pend_hit;
  logic [47:0]   pend_mac;
  logic          armed;

  logic handshake, match, xfer, last_xfer, timeout, can_retry;

  assign handshake = req_valid && armed && (state == IDLE);
  assign match     = arp_reply_valid && (arp_reply_ip == target);
  assign xfer      = (state == SEND) && tx_tready;
  assign last_xfer = xfer && (byte_idx == LAST_IDX);
  assign can_retry = retry_cnt < MAX_RETRY;
  assign tx_tuser  = 1'b0;

  arp_req_timer #(
    .timeout_cycles(timeout_cycles)
  ) u_timer (
    .clk   (clk),
    .resetn(resetn),
    .clr   (last_xfer),
    .en    (state == WAIT),
    .tc    (timeout)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    tx_tvalid = 1'b0;
    tx_tdata  = 8'h00;
    tx_tlast  = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = armed;
        if (handshake) state_nxt = SEND;
      end
      SEND: begin
        tx_tvalid = 1'b1;
        tx_tdata  = arp_frame_byte(byte_idx, local_mac, local_ip, target);
        tx_tlast  = (byte_idx == LAST_IDX);
        // A reply seen while the frame was still going out skips WAIT entirely.
        if (last_xfer) state_nxt = (pend_hit || match) ? DONE : WAIT;
      end
      WAIT: begin
        if (match)                       state_nxt = DONE;
        else if (timeout && can_retry)   state_nxt = SEND;
        else if (timeout)                state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      armed     <= 1'b0;
      byte_idx  <= '0;
      target    <= '0;
      retry_cnt <= '0;
      pend_hit  <= 1'b0;
      pend_mac  <= '0;
      res_fail  <= 1'b0;
      res_mac   <= '0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (handshake) begin
            target    <= req_ip;
            retry_cnt <= '0;
            byte_idx  <= '0;
            pend_hit  <= 1'b0;
          end
        end
        SEND: begin
          if (match) begin
            pend_hit <= 1'b1;
            pend_mac <= arp_reply_mac;
          end
          if (xfer && !last_xfer) byte_idx <= byte_idx + 6'd1;
          if (last_xfer && (pend_hit || match)) begin
            res_mac  <= match ? arp_reply_mac : pend_mac;
            res_fail <= 1'b0;
          end
        end
        WAIT: begin
          if (match) begin
            res_mac  <= arp_reply_mac;
            res_fail <= 1'b0;
          end else if (timeout) begin
            if (can_retry) begin
              retry_cnt <= retry_cnt + RW'(1);
              byte_idx  <= '0;
            end else begin
              res_fail <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arp_request.sv
// tb/tb_arp_request.sv - arp_request bench: directed scenarios plus randomized traffic against a transaction-level model
`timescale 1ns/1ps
module tb_arp_request;

  localparam logic [47:0] LMAC    = 48'h00_0a_35_01_02_03;
  localparam logic [31:0] LIP     = 32'h10_00_00_80;
  localparam int          TMO     = 64;
  localparam int          RETRIES = 2;
`ifdef ARP_REQ_PAD_EN
  localparam int FLEN = 60;
`else
  localparam int FLEN = 42;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid, req_ready;
  logic [31:0] req_ip;
  logic        tx_tvalid, tx_tready, tx_tlast, tx_tuser;
  logic [7:0]  tx_tdata;
  logic        arp_reply_valid;
  logic [31:0] arp_reply_ip;
  logic [47:0] arp_reply_mac;
  logic        res_valid, res_fail;
  logic [47:0] res_mac;

  arp_request #(
    .local_mac(LMAC), .local_ip(LIP), .timeout_cycles(TMO), .max_retries(RETRIES)
  ) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_ip(req_ip),
    .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tdata(tx_tdata),
    .tx_tlast(tx_tlast), .tx_tuser(tx_tuser),
    .arp_reply_valid(arp_reply_valid), .arp_reply_ip(arp_reply_ip), .arp_reply_mac(arp_reply_mac),
    .res_valid(res_valid), .res_fail(res_fail), .res_mac(res_mac)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected frame byte straight from the field list: 42-byte header, zero beyond.
  function automatic logic [7:0] exp_byte(input int i, input logic [31:0] tgt);
    logic [8*42-1:0] hdr;
    hdr = {48'hffff_ffff_ffff, LMAC, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
           16'h0001, LMAC, LIP, 48'h0, tgt};
    if (i >= 42) return 8'h00;
    return hdr[8*(41-i) +: 8];
  endfunction

  logic bp_en = 1'b0;
  always @(posedge clk) begin
    #1;
    tx_tready = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Transaction-level model: what is in flight, how many bytes accepted, when the frame ended.
  bit          m_armed = 0, m_busy = 0, m_send = 0, m_wait = 0, m_rep = 0, m_fail = 0;
  int          m_nb = 0, m_tend = 0, m_att = 0, m_due = -1;
  logic [31:0] m_tgt = 0;
  logic [47:0] m_pmac = 0, m_mac = 0;
  int          n_frames = 0, last_cyc = 0, n_res = 0, res_cyc = 0;
  logic        last_fail = 1'b0;
  logic [7:0]  cap [0:63];

  always @(negedge clk) begin
    bit match, exp_ready;
    if (!resetn) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_tvalid", tx_tvalid, 0);
      chk("rst_tdata", tx_tdata, 0);
      chk("rst_tlast", tx_tlast, 0);
      chk("rst_tuser", tx_tuser, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_fail", res_fail, 0);
      chk("rst_res_mac", res_mac, 0);
      m_armed = 0; m_busy = 0; m_send = 0; m_wait = 0; m_due = -1; m_mac = 0;
    end else begin
      exp_ready = m_armed && !m_busy;
      chk("req_ready", req_ready, exp_ready);
      chk("tvalid", tx_tvalid, m_send);
      chk("tuser", tx_tuser, 0);
      if (m_send) begin
        chk("tdata", tx_tdata, exp_byte(m_nb, m_tgt));
        chk("tlast", tx_tlast, (m_nb == FLEN - 1));
      end
      chk("res_valid", res_valid, (m_due == cyc));
      if (m_due == cyc) chk("res_fail", res_fail, m_fail);
      chk("res_mac", res_mac, m_mac);
      if (res_valid) begin
        n_res++; res_cyc = cyc; last_fail = res_fail;
      end

      match = arp_reply_valid && (arp_reply_ip == m_tgt) && (m_send || m_wait);
      if (m_due == cyc) begin
        m_busy = 0; m_due = -1;
      end else if (m_send) begin
        if (match) begin m_rep = 1; m_pmac = arp_reply_mac; end
        if (tx_tready) begin
          cap[m_nb] = tx_tdata;
          m_nb++;
          if (m_nb == FLEN) begin
            m_send = 0; n_frames++; last_cyc = cyc;
            if (m_rep) begin m_due = cyc + 1; m_fail = 0; m_mac = m_pmac; end
            else begin m_wait = 1; m_tend = cyc; end
          end
        end
      end else if (m_wait) begin
        if (match) begin
          m_wait = 0; m_due = cyc + 1; m_fail = 0; m_mac = arp_reply_mac;
        end else if (cyc == m_tend + TMO) begin
          m_wait = 0;
          if (m_att < RETRIES) begin m_att++; m_send = 1; m_nb = 0; end
          else begin m_due = cyc + 1; m_fail = 1; end
        end
      end else if (exp_ready && req_valid) begin
        m_busy = 1; m_tgt = req_ip; m_att = 0; m_rep = 0; m_send = 1; m_nb = 0;
      end
      m_armed = 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [31:0] ip, output int h);
    int k;
    k = 0;
    while (!req_ready && k < 3000) begin tick(); k++; end
    chk("req_ready_bound", req_ready, 1);
    req_valid = 1'b1; req_ip = ip; h = cyc;
    tick();
    req_valid = 1'b0; req_ip = $urandom;
  endtask

  task automatic reply(input logic [31:0] ip, input logic [47:0] mac);
    arp_reply_valid = 1'b1; arp_reply_ip = ip; arp_reply_mac = mac;
    tick();
    arp_reply_valid = 1'b0; arp_reply_ip = $urandom; arp_reply_mac = {16'($urandom), $urandom};
  endtask

  task automatic wait_frames(input int target, output int fl);
    int k;
    k = 0;
    while (n_frames < target && k < 3000) begin tick(); k++; end
    chk("frame_wait_bound", (n_frames >= target), 1);
    fl = last_cyc;
  endtask

  task automatic wait_res(input int n0, output int rc);
    int k;
    k = 0;
    while (n_res == n0 && k < 3000) begin tick(); k++; end
    chk("res_wait_bound", (n_res != n0), 1);
    rc = res_cyc;
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: run still going at cycle %0d, expected finish", cyc);
    $fatal(1);
  end

  initial begin
    int h, rc, fl, f0, n0;
    req_valid = 0; req_ip = 0; arp_reply_valid = 0; arp_reply_ip = 0; arp_reply_mac = 0;
    tx_tready = 1;
    repeat (3) tick();
    chk("ready_held_in_reset", req_ready, 0);
    resetn = 1'b1;
    tick();
    chk("ready_after_release", req_ready, 1);

    // Basic resolve
    f0 = n_frames; n0 = n_res;
    do_req(32'h10_00_00_01, h);
    wait_frames(f0 + 1, fl);
    chk("basic_last_byte_cyc", fl - h, FLEN);
    while (cyc < h + 100) tick();
    reply(32'h10_00_00_01, 48'h02_11_22_33_44_55);
    wait_res(n0, rc);
    chk("basic_res_cyc", rc - h, 101);
    chk("basic_res_mac", res_mac, 48'h02_11_22_33_44_55);
    chk("basic_fail_flag", last_fail, 0);
    chk("basic_frames", n_frames - f0, 1);
    chk("basic_byte0", cap[0], 8'hff);
    chk("basic_byte12", cap[12], 8'h08);
    chk("basic_byte13", cap[13], 8'h06);
    chk("basic_byte21", cap[21], 8'h01);
    chk("basic_byte38", cap[38], 8'h10);
    chk("basic_byte41", cap[41], 8'h01);

    // Backpressure
    bp_en = 1'b1;
    f0 = n_frames; n0 = n_res;
    do_req(32'h0a_00_00_03, h);
    wait_frames(f0 + 1, fl);
    while (cyc < fl + 5) tick();
    reply(32'h0a_00_00_03, 48'ha0_b0_c0_d0_e0_f0);
    wait_res(n0, rc);
    chk("bp_frames", n_frames - f0, 1);
    chk("bp_res_mac", res_mac, 48'ha0_b0_c0_d0_e0_f0);
    bp_en = 1'b0;
    tick();

    // Retry and fail
    f0 = n_frames; n0 = n_res;
    do_req(32'h0a_00_00_05, h);
    wait_res(n0, rc);
    chk("fail_res_cyc", rc - h, 3 * (FLEN + TMO) + 1);
    chk("fail_frames", n_frames - f0, 3);
    chk("fail_flag", last_fail, 1);
    chk("fail_mac_held", res_mac, 48'ha0_b0_c0_d0_e0_f0);

    // Filtering, correct reply exactly on the timeout cycle
    f0 = n_frames; n0 = n_res;
    do_req(32'h0a_00_00_07, h);
    wait_frames(f0 + 1, fl);
    while (cyc < fl + 5) tick();
    reply(32'h0a_00_00_02, 48'h11_11_11_11_11_11);
    while (cyc < fl + TMO) tick();
    reply(32'h0a_00_00_07, 48'h0c_0d_0e_0f_10_11);
    wait_res(n0, rc);
    chk("filt_res_cyc", rc - fl, TMO + 1);
    chk("filt_frames", n_frames - f0, 1);
    chk("filt_res_mac", res_mac, 48'h0c_0d_0e_0f_10_11);

    // Reply while the frame is still going out (byte 10)
    f0 = n_frames; n0 = n_res;
    do_req(32'h0a_00_00_09, h);
    while (cyc < h + 11) tick();
    reply(32'h0a_00_00_09, 48'h0a_0b_0c_0d_0e_0f);
    wait_res(n0, rc);
    chk("send_reply_res_cyc", rc - h, FLEN + 1);
    chk("send_reply_frames", n_frames - f0, 1);
    chk("send_reply_mac", res_mac, 48'h0a_0b_0c_0d_0e_0f);

    // Reset at byte 20, then a fresh request
    do_req(32'h0a_00_00_0b, h);
    while (cyc < h + 21) tick();
    resetn = 1'b0;
    #1;
    chk("rst_mid_tvalid", tx_tvalid, 0);
    chk("rst_mid_res_mac", res_mac, 0);
    tick(); tick();
    resetn = 1'b1;
    tick();
    chk("rst_mid_ready", req_ready, 1);
    f0 = n_frames; n0 = n_res;
    do_req(32'h0a_00_00_0c, h);
    wait_frames(f0 + 1, fl);
    chk("rst_fresh_frame_len", fl - h, FLEN);
    while (cyc < fl + 3) tick();
    reply(32'h0a_00_00_0c, 48'h12_34_56_78_9a_bc);
    wait_res(n0, rc);
    chk("rst_fresh_mac", res_mac, 48'h12_34_56_78_9a_bc);

    // Randomized traffic with backpressure
    bp_en = 1'b1;
    for (int it = 0; it < 25; it++) begin
      logic [31:0] ip;
      int r, k;
      bit right;
      ip = $urandom;
      r = $urandom_range(1, 300);
      right = ($urandom_range(0, 3) != 0);
      n0 = n_res;
      do_req(ip, h);
      k = 1;
      while (!(k > r && n_res != n0) && k < 3000) begin
        if (k == r) begin
          arp_reply_valid = 1'b1;
          arp_reply_ip = right ? ip : ~ip;
          arp_reply_mac = {16'($urandom), $urandom};
        end else begin
          arp_reply_valid = 1'b0;
        end
        tick();
        k++;
      end
      arp_reply_valid = 1'b0;
      chk("rand_res_seen", (n_res != n0), 1);
    end
    bp_en = 1'b0;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
